rx_chan_scheduler: RTL and testbench
====================================

# rx_chan_scheduler

Round-robin scheduler that decides which RX channel FIFO the packet builder drains next and how many samples go into the packet. It sits between the per-channel RX sample FIFOs and the packet builder on the `rxclk` domain, replacing the builder's ad hoc channel polling. It also tracks per-channel age for partial-packet flushes and sticky overrun flags, and presents each decision through a valid/ack/done handshake.

## Interface
- `NUM_CHAN`, default 2: highest channel index; channels 0..NUM_CHAN, channel 0 is the control channel.
- `PKT_WORDS`, default 504: full-packet payload threshold, in 16-bit words.
- `FULL_WORDS`, default 1016: FIFO level at or above which a stalled channel is flagged overrun.
- `FLUSH_CYCLES`, default 4096: age at which a non-empty, under-threshold channel is flushed.

Ports:
- `rxclk` in 1: sole clock.
- `reset` in 1: reset, **synchronous, active-low**.
- `channels` in 4: highest enabled channel index; indices above it are never granted.
- `chan_usedw` in 10*(NUM_CHAN+1): per-channel FIFO fill, in words; channel i occupies bits [10i+9:10i].
- `have_space` in 1: USB-side FIFO can accept one full packet.
- `grant_valid` out 1: a grant is presented.
- `grant_chan` out 4: granted channel index.
- `grant_len` out 9: words to read, min(usedw, PKT_WORDS).
- `grant_partial` out 1: grant issued by age flush, not by threshold.
- `grant_overrun` out 1: granted channel's overrun flag, as sampled at grant.
- `grant_ack` in 1: builder accepted the grant.
- `pkt_done` in 1: builder finished the granted packet (one-cycle pulse).
- `overrun` out NUM_CHAN+1: live sticky overrun flags.

## Operation
- Eligibility of channel i: i ≤ `channels` AND either usedw[i] ≥ PKT_WORDS, or (usedw[i] > 0 AND age[i] ≥ FLUSH_CYCLES).
- Selection is rotating priority, starting at `ptr` and ascending with wrap. The search covers ptr..`channels`, then 0..ptr−1. The first eligible index wins.
- FSM states:
  - SCAN: when at least one channel is eligible and `have_space`=1, register grant_* and go to GRANT. Otherwise stay in SCAN.
  - GRANT: `grant_valid`=1, and grant_* are held stable. On `grant_ack` go to BUSY and drop `grant_valid`.
  - BUSY: wait for `pkt_done`, then go to SCAN with `ptr` ← (grant_chan == `channels`) ? 0 : grant_chan+1.
- Age counters, 13 bits, saturating at FLUSH_CYCLES:
  - Reset to 0 when usedw[i] = 0, or on the `grant_ack` cycle for channel i.
  - Otherwise increment by 1 per cycle.
- Overrun flags:
  - overrun[i] is set on any cycle with usedw[i] ≥ FULL_WORDS while i is not the channel in GRANT/BUSY.
  - Cleared on the `grant_ack` cycle for channel i; clear takes priority over set.
- `grant_overrun` is the flag value captured when the grant is registered.
- `grant_partial` = 1 only if usedw < PKT_WORDS at selection.
- If `ptr` > `channels` (because `channels` shrank), the search starts from 0.
- `pkt_done` outside BUSY is ignored. `grant_ack` outside GRANT is ignored.

## Timing
- Reset values: `grant_valid`=0, `grant_chan`=0, `grant_len`=0, `grant_partial`=0, `grant_overrun`=0, `overrun`=0. Also: ages 0, `ptr`=0, state SCAN.
- Reset asserted in any state returns to SCAN on the next edge; an outstanding grant is abandoned.
- Grant latency: eligibility and `have_space` sampled at edge N → `grant_valid`=1 after edge N+1.
- `grant_valid` falls on the edge that samples `grant_ack`.
- The earliest next `grant_valid` is 1 cycle after the edge that samples `pkt_done` (SCAN evaluates once, then the grant is registered).
- usedw changes during GRANT/BUSY do not alter grant_*.
- `have_space` is checked only in SCAN.

## Test plan
- Channel 1 usedw=600, others 0, `have_space`=1 → `grant_valid` in 2 cycles with chan=1, len=504, partial=0. Then ack, done, and `ptr` moves to 2.
- Channels 0, 1, 2 all at 504, with repeated ack/done → grants in the order 0, 1, 2, 0. With `channels`=1 the order is 0, 1, 0.
- Channel 2 usedw=10 held constant → no grant before age reaches 4096. A grant then follows with len=10, partial=1, and age returns to 0 after ack.
- `have_space`=0 while channel 1 rises to 1016 → overrun[1]=1 and no grant. Raising `have_space` gives a grant with grant_overrun=1, and overrun[1]=0 after ack.
- Assert reset mid-BUSY → all outputs return to zero next cycle, and a late `pkt_done` is ignored.
- Change usedw and `have_space` during GRANT → grant_chan and grant_len stay unchanged until `grant_ack`.

Source files
------------

// File: rtl/rx_chan_scheduler.sv
// Round-robin scheduler choosing which RX channel FIFO the packet builder drains next,
// with per-channel flush ageing, sticky overrun flags and a valid/ack/done grant handshake.
module rx_chan_scheduler #(
    parameter int unsigned NUM_CHAN     = 2,
    parameter int unsigned PKT_WORDS    = 504,
    parameter int unsigned FULL_WORDS   = 1016,
    parameter int unsigned FLUSH_CYCLES = 4096
) (
    input  logic                        rxclk,
    input  logic                        reset,
    input  logic [3:0]                  channels,
    input  logic [10*(NUM_CHAN+1)-1:0]  chan_usedw,
    input  logic                        have_space,
    output logic                        grant_valid,
    output logic [3:0]                  grant_chan,
    output logic [8:0]                  grant_len,
    output logic                        grant_partial,
    output logic                        grant_overrun,
    input  logic                        grant_ack,
    input  logic                        pkt_done,
    output logic [NUM_CHAN:0]           overrun
);

    localparam int unsigned NCH     = NUM_CHAN + 1;
    localparam logic [9:0]  PktW    = 10'(PKT_WORDS);
    localparam logic [9:0]  FullW   = 10'(FULL_WORDS);
    localparam logic [12:0] FlushA  = 13'(FLUSH_CYCLES);
    localparam logic [3:0]  LastIdx = 4'(NUM_CHAN);

    typedef enum logic [1:0] {StScan, StGrant, StBusy} state_e;

    state_e            state_q, state_d;
    logic [3:0]        ptr_q, ptr_d;
    logic [12:0]       age_q [NCH];
    logic [12:0]       age_d [NCH];
    logic [9:0]        usedw [NCH];
    logic [9:0]        usedw_q [NCH];
    logic [NUM_CHAN:0] elig_q, elig_d;
    logic [NUM_CHAN:0] overrun_q, overrun_d;
    logic [NUM_CHAN:0] ack_hit, active;
    logic              have_space_q;

    logic [3:0]        start, sel, sel_hi, sel_lo;
    logic              hit_hi, hit_lo, found, load;
    logic [9:0]        sel_used;
    logic              sel_ovr;

    always_comb begin
        for (int i = 0; i < int'(NCH); i++) begin
            usedw[i]   = chan_usedw[10*i +: 10];
            ack_hit[i] = (state_q == StGrant) && grant_ack && (grant_chan == 4'(i));
            active[i]  = (state_q != StScan) && (grant_chan == 4'(i));
        end
    end

    // Eligibility and usedw are registered so selection sees a one-cycle-old snapshot.
    always_comb begin
        for (int i = 0; i < int'(NCH); i++) begin
            elig_d[i] = (usedw[i] >= PktW) || ((usedw[i] != 10'd0) && (age_q[i] >= FlushA));
            if (usedw[i] == 10'd0 || ack_hit[i]) begin
                age_d[i] = 13'd0;
            end else if (age_q[i] < FlushA) begin
                age_d[i] = age_q[i] + 13'd1;
            end else begin
                age_d[i] = age_q[i];
            end
            overrun_d[i] = ack_hit[i] ? 1'b0
                         : (overrun_q[i] | ((usedw[i] >= FullW) && !active[i]));
        end
    end

    // Rotating priority: lowest eligible index at/above start, else lowest below it.
    always_comb begin
        start  = (ptr_q > channels) ? 4'd0 : ptr_q;
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        sel_hi = 4'd0;
        sel_lo = 4'd0;
        for (int i = int'(NUM_CHAN); i >= 0; i--) begin
            if (elig_q[i] && (4'(i) <= channels)) begin
                if (4'(i) >= start) begin
                    hit_hi = 1'b1;
                    sel_hi = 4'(i);
                end else begin
                    hit_lo = 1'b1;
                    sel_lo = 4'(i);
                end
            end
        end
        found    = hit_hi | hit_lo;
        sel      = hit_hi ? sel_hi : sel_lo;
        sel_used = 10'd0;
        sel_ovr  = 1'b0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (sel == 4'(i)) begin
                sel_used = usedw_q[i];
                sel_ovr  = overrun_q[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        load    = 1'b0;
        unique case (state_q)
            StScan: begin
                if (found && have_space_q) begin
                    load    = 1'b1;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (grant_ack) state_d = StGrant == state_q ? StBusy : state_q;
            end
            StBusy: begin
                if (pkt_done) begin
                    state_d = StScan;
                    ptr_d   = (grant_chan == channels || grant_chan == LastIdx) ? 4'd0
                                                                             : grant_chan + 4'd1;
                end
            end
            default: state_d = StScan;
        endcase
    end

    always_ff @(posedge rxclk) begin
        if (!reset) begin
            state_q       <= StScan;
            ptr_q         <= 4'd0;
            elig_q        <= '0;
            overrun_q     <= '0;
            have_space_q  <= 1'b0;
            grant_chan    <= 4'd0;
            grant_len     <= 9'd0;
            grant_partial <= 1'b0;
            grant_overrun <= 1'b0;
            for (int i = 0; i < int'(NCH); i++) begin
                age_q[i]   <= 13'd0;
                usedw_q[i] <= 10'd0;
            end
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            elig_q       <= elig_d;
            overrun_q    <= overrun_d;
            have_space_q <= have_space;
            for (int i = 0; i < int'(NCH); i++) begin
                age_q[i]   <= age_d[i];
                usedw_q[i] <= usedw[i];
            end
            if (load) begin
                grant_chan    <= sel;
                grant_len     <= (sel_used >= PktW) ? 9'(PktW) : 9'(sel_used);
                grant_partial <= (sel_used < PktW);
                grant_overrun <= sel_ovr;
            end
        end
    end

    assign grant_valid = (state_q == StGrant);
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_rx_chan_scheduler.sv
// Scoreboard bench for rx_chan_scheduler: directed stimulus pushes expected grants,
// a negedge monitor pops and compares them for every cycle a grant is presented.
module tb_rx_chan_scheduler;

    localparam int NUM_CHAN = 2;

    logic                       rxclk;
    logic                       reset;
    logic [3:0]                 channels;
    logic [10*(NUM_CHAN+1)-1:0] chan_usedw;
    logic                       have_space;
    logic                       grant_valid;
    logic [3:0]                 grant_chan;
    logic [8:0]                 grant_len;
    logic                       grant_partial;
    logic                       grant_overrun;
    logic                       grant_ack;
    logic                       pkt_done;
    logic [NUM_CHAN:0]          overrun;

    rx_chan_scheduler #(
        .NUM_CHAN     (NUM_CHAN),
        .PKT_WORDS    (504),
        .FULL_WORDS   (1016),
        .FLUSH_CYCLES (4096)
    ) dut (
        .rxclk         (rxclk),
        .reset         (reset),
        .channels      (channels),
        .chan_usedw    (chan_usedw),
        .have_space    (have_space),
        .grant_valid   (grant_valid),
        .grant_chan    (grant_chan),
        .grant_len     (grant_len),
        .grant_partial (grant_partial),
        .grant_overrun (grant_overrun),
        .grant_ack     (grant_ack),
        .pkt_done      (pkt_done),
        .overrun       (overrun)
    );

    typedef struct packed {
        logic [3:0] chan;
        logic [8:0] len;
        logic       partial;
        logic       ovr;
    } grant_t;

    grant_t exp_q[$];
    int     checks = 0;
    int     errors = 0;

    initial begin
        rxclk = 1'b0;
        forever #5 rxclk = ~rxclk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int c, input int l, input int p, input int o);
        grant_t g;
        g.chan    = 4'(c);
        g.len     = 9'(l);
        g.partial = 1'(p);
        g.ovr     = 1'(o);
        exp_q.push_back(g);
    endtask

    task automatic set_used(input int c, input int v);
        chan_usedw[10*c +: 10] = 10'(v);
    endtask

    task automatic check_idle(input string name);
        check({name, "_valid"}, int'(grant_valid), 0);
        check({name, "_chan"}, int'(grant_chan), 0);
        check({name, "_len"}, int'(grant_len), 0);
        check({name, "_partial"}, int'(grant_partial), 0);
        check({name, "_govr"}, int'(grant_overrun), 0);
        check({name, "_overrun"}, int'(overrun), 0);
    endtask

    task automatic do_reset();
        @(negedge rxclk);
        reset      = 1'b0;
        grant_ack  = 1'b0;
        pkt_done   = 1'b0;
        have_space = 1'b0;
        chan_usedw = '0;
        channels   = 4'd2;
        @(negedge rxclk);
        @(negedge rxclk);
        reset = 1'b1;
    endtask

    task automatic wait_grant(input string name, input int bound, output int n);
        n = 0;
        do begin
            @(negedge rxclk);
            n++;
        end while (!grant_valid && n < bound);
        check({name, "_seen"}, int'(grant_valid), 1);
    endtask

    task automatic ack_done(input int busy);
        grant_ack = 1'b1;
        @(negedge rxclk);
        grant_ack = 1'b0;
        repeat (busy) @(negedge rxclk);
        pkt_done = 1'b1;
        @(negedge rxclk);
        pkt_done = 1'b0;
    endtask

    // Monitor: a rising grant_valid pops the next expectation; it is rechecked every held cycle.
    initial begin
        grant_t cur;
        logic   prev_valid;
        logic   have_cur;
        prev_valid = 1'b0;
        have_cur   = 1'b0;
        cur        = '0;
        forever begin
            @(negedge rxclk);
            if (grant_valid) begin
                if (!prev_valid) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        have_cur = 1'b0;
                        $display("FAIL unexpected_grant: got chan %0d len %0d expected no grant",
                                 grant_chan, grant_len);
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                    end
                end
                if (have_cur) begin
                    check("mon_chan", int'(grant_chan), int'(cur.chan));
                    check("mon_len", int'(grant_len), int'(cur.len));
                    check("mon_partial", int'(grant_partial), int'(cur.partial));
                    check("mon_govr", int'(grant_overrun), int'(cur.ovr));
                end
            end
            prev_valid = grant_valid;
        end
    end

    initial begin
        int n;
        int seen;
        int order [9] = '{2, 0, 1, 2, 0, 1, 0, 1, 0};

        reset      = 1'b0;
        grant_ack  = 1'b0;
        pkt_done   = 1'b0;
        have_space = 1'b0;
        chan_usedw = '0;
        channels   = 4'd2;
        do_reset();
        check_idle("reset");

        // Threshold grant with two-cycle latency, then rotation (incl. channels shrinking).
        have_space = 1'b1;
        push(1, 504, 0, 0);
        set_used(1, 600);
        wait_grant("first", 10, n);
        check("grant_latency", n, 2);
        for (int k = 0; k < 9; k++) push(order[k], 504, 0, 0);
        set_used(0, 504);
        set_used(1, 504);
        set_used(2, 504);
        ack_done(1);
        for (int k = 0; k < 9; k++) begin
            wait_grant("order", 20, n);
            if (k == 8) chan_usedw = '0;
            ack_done(1);
            if (k == 5) channels = 4'd1;
        end
        repeat (10) @(negedge rxclk);

        // Age flush of a small, constant fill.
        do_reset();
        have_space = 1'b1;
        push(2, 10, 1, 0);
        set_used(2, 10);
        wait_grant("flush", 5000, n);
        check("flush_latency", n, 4098);
        ack_done(2);
        seen = 0;
        repeat (200) begin
            @(negedge rxclk);
            if (grant_valid) seen++;
        end
        check("flush_rearm", seen, 0);

        // Overrun while blocked by have_space.
        do_reset();
        set_used(1, 1016);
        repeat (3) @(negedge rxclk);
        check("ovr_set", int'(overrun), 2);
        check("ovr_no_grant", int'(grant_valid), 0);
        push(1, 504, 0, 1);
        have_space = 1'b1;
        wait_grant("ovr", 10, n);
        grant_ack = 1'b1;
        @(negedge rxclk);
        grant_ack = 1'b0;
        check("ovr_clear", int'(overrun), 0);
        @(negedge rxclk);
        check("ovr_busy_hold", int'(overrun), 0);
        chan_usedw = '0;
        pkt_done   = 1'b1;
        @(negedge rxclk);
        pkt_done = 1'b0;
        repeat (5) @(negedge rxclk);

        // Grant stays stable while inputs move; pkt_done in GRANT is ignored.
        do_reset();
        have_space = 1'b1;
        push(1, 504, 0, 0);
        set_used(1, 600);
        wait_grant("stable", 10, n);
        set_used(1, 100);
        set_used(2, 700);
        have_space = 1'b0;
        pkt_done   = 1'b1;
        @(negedge rxclk);
        pkt_done = 1'b0;
        check("done_in_grant", int'(grant_valid), 1);
        repeat (2) @(negedge rxclk);
        chan_usedw = '0;
        ack_done(1);
        repeat (5) @(negedge rxclk);

        // Reset during BUSY, then a stray pkt_done must not move the pointer.
        do_reset();
        have_space = 1'b1;
        push(0, 504, 0, 0);
        set_used(0, 504);
        wait_grant("rst", 10, n);
        grant_ack = 1'b1;
        @(negedge rxclk);
        grant_ack  = 1'b0;
        chan_usedw = '0;
        reset      = 1'b0;
        @(negedge rxclk);
        check_idle("rst_busy");
        reset    = 1'b1;
        pkt_done = 1'b1;
        @(negedge rxclk);
        pkt_done = 1'b0;
        repeat (3) @(negedge rxclk);
        check("late_done_idle", int'(grant_valid), 0);
        push(0, 504, 0, 0);
        set_used(0, 504);
        set_used(1, 504);
        wait_grant("after_rst", 10, n);
        chan_usedw = '0;
        ack_done(1);
        repeat (10) @(negedge rxclk);

        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
